// File: rtl/agu_issue_queue_param_if.sv
// Common data bus broadcast: one tag/data result per cycle from the writeback stage.
interface cdb_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [XLEN-1:0]  data;

  modport master (output valid, tag, data);
  modport slave  (input  valid, tag, data);
endinterface

// File: rtl/agu_issue_queue_param.sv
// Age-ordered AGU reservation queue: captures CDB operands, issues oldest ready op1+imm.
// Optional macro AGU_STORE_ORDER_EN keeps stores in order and stops loads passing older stores.
module agu_issue_queue_param #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       queue_en,
  input  logic [XLEN-1:0]            queue_op1_data_in,
  input  logic [XLEN-1:0]            queue_op2_data_in,
  input  logic [TAG_W-1:0]           queue_op1_tag_in,
  input  logic [TAG_W-1:0]           queue_op2_tag_in,
  input  logic                       queue_op1_data_valid_in,
  input  logic                       queue_op2_data_valid_in,
  input  logic [TAG_W-1:0]           queue_rd_tag_in,
  input  logic                       queue_rd_tag_valid_in,
  input  logic [2:0]                 queue_funct3_in,
  input  logic                       queue_agu_ls_in,
  input  logic [XLEN-1:0]            queue_agu_imm_in,
  output logic                       queue_full,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  cdb_if.slave                       cdb,
  input  logic                       ex_done,
  output logic                       issue_valid,
  output logic [XLEN-1:0]            ex_address,
  output logic [XLEN-1:0]            ex_data,
  output logic [TAG_W-1:0]           queue_rd_tag_out,
  output logic                       queue_rd_tag_valid_out,
  output logic [2:0]                 queue_funct3_out,
  output logic                       queue_agu_ls_out
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic             ls;
    logic [2:0]       funct3;
    logic             rd_v;
    logic [TAG_W-1:0] rd_tag;
    logic             op1_v;
    logic [TAG_W-1:0] op1_tag;
    logic [XLEN-1:0]  op1;
    logic             op2_v;
    logic [TAG_W-1:0] op2_tag;
    logic [XLEN-1:0]  op2;
    logic [XLEN-1:0]  imm;
  } entry_t;

  // Latch a CDB result into any still-pending operand whose tag matches.
  function automatic entry_t capture(input entry_t e, input logic v,
                                     input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    entry_t r;
    r = e;
    if (e.valid && v && !e.op1_v && (e.op1_tag == t)) begin
      r.op1   = d;
      r.op1_v = 1'b1;
    end else begin
      r.op1_v = e.op1_v;
    end
    if (e.valid && v && !e.op2_v && (e.op2_tag == t)) begin
      r.op2   = d;
      r.op2_v = 1'b1;
    end else begin
      r.op2_v = e.op2_v;
    end
    return r;
  endfunction

  entry_t         ent_q [DEPTH];
  entry_t         ent_d [DEPTH];
  entry_t         ext_s [DEPTH+1];
  entry_t         new_ent_s;
  entry_t         sel_ent_s;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  wr_idx_s;
  logic [DEPTH-1:0] elig_s;
  logic [IW-1:0]  sel_idx_s;
  logic           issue_valid_s;
  logic           store_seen_s;
  logic           disp_acc_s;
  logic           issue_acc_s;

  assign queue_full  = (count_q == CW'(DEPTH));
  assign queue_count = count_q;

  // Eligibility and oldest-first selection from registered state only.
  always_comb begin
    elig_s        = '0;
    store_seen_s  = 1'b0;
    sel_idx_s     = '0;
    issue_valid_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef AGU_STORE_ORDER_EN
      elig_s[i] = ent_q[i].valid && ent_q[i].op1_v && (!ent_q[i].ls || ent_q[i].op2_v)
                  && !store_seen_s && (!ent_q[i].ls || (i == 0));
`else
      elig_s[i] = ent_q[i].valid && ent_q[i].op1_v && (!ent_q[i].ls || ent_q[i].op2_v);
`endif
      store_seen_s = store_seen_s | (ent_q[i].valid & ent_q[i].ls);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig_s[i]) begin
        sel_idx_s     = IW'(i);
        issue_valid_s = 1'b1;
      end else begin
        sel_idx_s     = sel_idx_s;
      end
    end
  end

  // Presented-entry outputs, forced to zero when nothing is eligible.
  always_comb begin
    sel_ent_s = ent_q[sel_idx_s];
    if (issue_valid_s) begin
      issue_valid            = 1'b1;
      ex_address             = sel_ent_s.op1 + sel_ent_s.imm;
      ex_data                = sel_ent_s.op2;
      queue_rd_tag_out       = sel_ent_s.rd_tag;
      queue_rd_tag_valid_out = sel_ent_s.rd_v;
      queue_funct3_out       = sel_ent_s.funct3;
      queue_agu_ls_out       = sel_ent_s.ls;
    end else begin
      issue_valid            = 1'b0;
      ex_address             = '0;
      ex_data                = '0;
      queue_rd_tag_out       = '0;
      queue_rd_tag_valid_out = 1'b0;
      queue_funct3_out       = 3'd0;
      queue_agu_ls_out       = 1'b0;
    end
  end

  // Next queue contents: collapse above the issued slot, capture CDB, append dispatch.
  always_comb begin
    issue_acc_s = issue_valid_s & ex_done;
    disp_acc_s  = queue_en & ~queue_full;
    wr_idx_s    = count_q - CW'(issue_acc_s);

    new_ent_s         = '0;
    new_ent_s.valid   = 1'b1;
    new_ent_s.ls      = queue_agu_ls_in;
    new_ent_s.funct3  = queue_funct3_in;
    new_ent_s.rd_v    = queue_rd_tag_valid_in;
    new_ent_s.rd_tag  = queue_rd_tag_in;
    new_ent_s.op1_v   = queue_op1_data_valid_in;
    new_ent_s.op1_tag = queue_op1_tag_in;
    new_ent_s.op1     = queue_op1_data_in;
    new_ent_s.op2_v   = queue_op2_data_valid_in;
    new_ent_s.op2_tag = queue_op2_tag_in;
    new_ent_s.op2     = queue_op2_data_in;
    new_ent_s.imm     = queue_agu_imm_in;
    new_ent_s         = capture(new_ent_s, cdb.valid, cdb.tag, cdb.data);

    ext_s[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ext_s[i] = ent_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_acc_s && (i >= int'(sel_idx_s))) begin
        ent_d[i] = capture(ext_s[i+1], cdb.valid, cdb.tag, cdb.data);
      end else begin
        ent_d[i] = capture(ext_s[i], cdb.valid, cdb.tag, cdb.data);
      end
      if (disp_acc_s && (CW'(i) == wr_idx_s)) begin
        ent_d[i] = new_ent_s;
      end else begin
        ent_d[i] = ent_d[i];
      end
    end

    count_d = count_q + CW'(disp_acc_s) - CW'(issue_acc_s);
  end

  // Queue state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end
endmodule

// File: tb/tb_agu_issue_queue_param.sv
// Bench for agu_issue_queue_param: directed vector table, then random traffic vs a queue model.
module tb_agu_issue_queue_param;
  logic        clk = 1'b0;
  logic        rst, en, v1_in, v2_in, rdv_in, ls_in, done;
  logic [31:0] op1_in, op2_in, imm_in;
  logic [5:0]  t1_in, t2_in, rd_in;
  logic [2:0]  f3_in;
  logic        full, issue_valid, rdv_out, ls_out;
  logic [2:0]  count, f3_out;
  logic [31:0] ex_address, ex_data;
  logic [5:0]  rd_out;
  int          n_pass = 0;
  int          n_total = 0;

  cdb_if #(.XLEN(32), .TAG_W(6)) cdb_bus ();

  agu_issue_queue_param #(.DEPTH(4), .XLEN(32), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .queue_en(en),
    .queue_op1_data_in(op1_in), .queue_op2_data_in(op2_in),
    .queue_op1_tag_in(t1_in), .queue_op2_tag_in(t2_in),
    .queue_op1_data_valid_in(v1_in), .queue_op2_data_valid_in(v2_in),
    .queue_rd_tag_in(rd_in), .queue_rd_tag_valid_in(rdv_in),
    .queue_funct3_in(f3_in), .queue_agu_ls_in(ls_in), .queue_agu_imm_in(imm_in),
    .queue_full(full), .queue_count(count), .cdb(cdb_bus.slave), .ex_done(done),
    .issue_valid(issue_valid), .ex_address(ex_address), .ex_data(ex_data),
    .queue_rd_tag_out(rd_out), .queue_rd_tag_valid_out(rdv_out),
    .queue_funct3_out(f3_out), .queue_agu_ls_out(ls_out)
  );

  always #5 clk = ~clk;

  // Reference model: a plain list of pending micro-ops, oldest first.
  typedef struct {
    logic [31:0] op1, op2, imm;
    logic        op1v, op2v, rdv, ls;
    logic [5:0]  t1, t2, rd;
    logic [2:0]  f3;
  } ment_t;
  ment_t m[$];

  typedef struct {
    logic rst, en, done, v1, v2, ls, cv;
    logic [31:0] op1, op2, imm, cd;
    logic [5:0] t1, t2, ct;
    logic e_valid, e_full;
    logic [31:0] e_addr, e_data;
    logic [2:0] e_count;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic int model_sel();
    bit store_before = 1'b0;
    for (int i = 0; i < m.size(); i++) begin
      bit ready = m[i].op1v && (!m[i].ls || m[i].op2v);
`ifdef AGU_STORE_ORDER_EN
      if (ready && !store_before && (!m[i].ls || i == 0)) return i;
`else
      if (ready) return i;
`endif
      if (m[i].ls) store_before = 1'b1;
    end
    return -1;
  endfunction

  task automatic model_update();
    int s = model_sel();
    if (rst) begin
      m.delete();
    end else begin
      bit fire = (s >= 0) && done;
      bit disp = en && (m.size() < 4);
      ment_t e;
      for (int i = 0; i < m.size(); i++) begin
        e = m[i];
        if (cdb_bus.valid && !e.op1v && e.t1 == cdb_bus.tag) begin e.op1 = cdb_bus.data; e.op1v = 1'b1; end
        if (cdb_bus.valid && !e.op2v && e.t2 == cdb_bus.tag) begin e.op2 = cdb_bus.data; e.op2v = 1'b1; end
        m[i] = e;
      end
      if (fire) m.delete(s);
      if (disp) begin
        e = '{op1: op1_in, op2: op2_in, imm: imm_in, op1v: v1_in, op2v: v2_in, rdv: rdv_in,
              ls: ls_in, t1: t1_in, t2: t2_in, rd: rd_in, f3: f3_in};
        if (cdb_bus.valid && !e.op1v && e.t1 == cdb_bus.tag) begin e.op1 = cdb_bus.data; e.op1v = 1'b1; end
        if (cdb_bus.valid && !e.op2v && e.t2 == cdb_bus.tag) begin e.op2 = cdb_bus.data; e.op2v = 1'b1; end
        m.push_back(e);
      end
    end
  endtask

  task automatic model_check();
    int s = model_sel();
    logic [31:0] ea = 32'd0, ed = 32'd0;
    logic [5:0] er = 6'd0;
    logic erv = 1'b0, els = 1'b0;
    logic [2:0] ef = 3'd0;
    if (s >= 0) begin
      ea = m[s].op1 + m[s].imm; ed = m[s].op2; er = m[s].rd;
      erv = m[s].rdv; els = m[s].ls; ef = m[s].f3;
    end
    chk("m_issue_valid", {31'd0, issue_valid}, {31'd0, (s >= 0)});
    chk("m_ex_address", ex_address, ea);
    chk("m_ex_data", ex_data, ed);
    chk("m_rd_tag", {26'd0, rd_out}, {26'd0, er});
    chk("m_rd_valid", {31'd0, rdv_out}, {31'd0, erv});
    chk("m_funct3", {29'd0, f3_out}, {29'd0, ef});
    chk("m_ls", {31'd0, ls_out}, {31'd0, els});
    chk("m_count", {29'd0, count}, m.size());
    chk("m_full", {31'd0, full}, {31'd0, (m.size() == 4)});
  endtask

  // Apply current inputs across one edge, then compare against the model.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    model_check();
  endtask

  task automatic d_row(input logic [31:0] op1, input logic v1, input logic [5:0] t1,
                       input logic [31:0] op2, input logic v2, input logic [5:0] t2,
                       input logic [31:0] imm, input logic ls, input logic cv, input logic [5:0] ct,
                       input logic [31:0] cd, input logic ev, input logic [31:0] ea,
                       input logic [31:0] ed, input logic [2:0] ec, input logic ef);
    vt.push_back('{rst: 1'b0, en: 1'b1, done: 1'b0, v1: v1, v2: v2, ls: ls, cv: cv, op1: op1, op2: op2,
                   imm: imm, cd: cd, t1: t1, t2: t2, ct: ct, e_valid: ev, e_full: ef,
                   e_addr: ea, e_data: ed, e_count: ec});
  endtask

  task automatic c_row(input logic r, input logic e, input logic dn, input logic cv,
                       input logic [5:0] ct, input logic [31:0] cd, input logic ev,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [2:0] ec, input logic ef);
    vt.push_back('{rst: r, en: e, done: dn, v1: 1'b1, v2: 1'b1, ls: 1'b0, cv: cv, op1: 32'h0, op2: 32'h0,
                   imm: 32'h0, cd: cd, t1: 6'd0, t2: 6'd0, ct: ct, e_valid: ev, e_full: ef,
                   e_addr: ea, e_data: ed, e_count: ec});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; done = 1'b0; v1_in = 1'b0; v2_in = 1'b0; rdv_in = 1'b0; ls_in = 1'b0;
    op1_in = 32'h0; op2_in = 32'h0; imm_in = 32'h0; t1_in = 6'd0; t2_in = 6'd0; rd_in = 6'd0;
    f3_in = 3'd0; cdb_bus.valid = 1'b0; cdb_bus.tag = 6'd0; cdb_bus.data = 32'h0;

    // Four ready loads, then drain with ex_done held.
    c_row(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      d_row(32'h1000 + i, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h4, 1'b0, 1'b0, 6'd0, 32'h0,
            1'b1, 32'h1004, 32'h0, 3'(i + 1), (i == 3));
    for (int i = 1; i <= 4; i++)
      c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, (i < 4), (i < 4) ? 32'h1004 + i : 32'h0,
            32'h0, 3'(4 - i), 1'b0);
    // Pending load is passed by a ready one, then woken by the CDB.
    d_row(32'h0, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h10, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd1, 1'b0);
    d_row(32'h300, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 32'h300, 32'h0, 3'd2, 1'b0);
    c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd1, 1'b0);
    c_row(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 32'h200, 1'b1, 32'h210, 32'h0, 3'd1, 1'b0);
    c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    // Dispatch-time bypass of the store data operand.
    d_row(32'h40, 1'b1, 6'd0, 32'h0, 1'b0, 6'd9, 32'h0, 1'b1, 1'b1, 6'd9, 32'hDEAD,
          1'b1, 32'h40, 32'hDEAD, 3'd1, 1'b0);
    c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    // Full queue: dispatch dropped during issue, then reset with three entries plus traffic.
    for (int i = 0; i < 4; i++)
      d_row(32'h2000 + i, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0,
            1'b1, 32'h2000, 32'h0, 3'(i + 1), (i == 3));
    c_row(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 32'h2001, 32'h0, 3'd3, 1'b0);
    c_row(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    // Older store with pending data, younger ready load.
    d_row(32'h80, 1'b1, 6'd0, 32'h0, 1'b0, 6'd7, 32'h4, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd1, 1'b0);
`ifdef AGU_STORE_ORDER_EN
    d_row(32'h90, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd2, 1'b0);
`else
    d_row(32'h90, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 32'h90, 32'h0, 3'd2, 1'b0);
`endif
    c_row(1'b0, 1'b0, 1'b0, 1'b1, 6'd7, 32'h55, 1'b1, 32'h84, 32'h55, 3'd2, 1'b0);
    c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 32'h90, 32'h0, 3'd1, 1'b0);
    c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    // Address wrap-around, and ex_done on an empty queue.
    d_row(32'hFFFFFFF0, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h20, 1'b0, 1'b0, 6'd0, 32'h0,
          1'b1, 32'h10, 32'h0, 3'd1, 1'b0);
    c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    c_row(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);

    for (int k = 0; k < vt.size(); k++) begin
      rst = vt[k].rst; en = vt[k].en; done = vt[k].done;
      op1_in = vt[k].op1; v1_in = vt[k].v1; t1_in = vt[k].t1;
      op2_in = vt[k].op2; v2_in = vt[k].v2; t2_in = vt[k].t2;
      imm_in = vt[k].imm; ls_in = vt[k].ls; rd_in = 6'(k); rdv_in = 1'b1; f3_in = 3'd2;
      cdb_bus.valid = vt[k].cv; cdb_bus.tag = vt[k].ct; cdb_bus.data = vt[k].cd;
      cycle();
      chk($sformatf("v%0d_issue_valid", k), {31'd0, issue_valid}, {31'd0, vt[k].e_valid});
      chk($sformatf("v%0d_ex_address", k), ex_address, vt[k].e_addr);
      chk($sformatf("v%0d_ex_data", k), ex_data, vt[k].e_data);
      chk($sformatf("v%0d_count", k), {29'd0, count}, {29'd0, vt[k].e_count});
      chk($sformatf("v%0d_full", k), {31'd0, full}, {31'd0, vt[k].e_full});
    end

    // Random traffic with a narrow tag space so captures and bypasses are frequent.
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 199) == 0);
      en     = ($urandom_range(0, 2) != 0);
      done   = ($urandom_range(0, 9) < 6);
      op1_in = $urandom; op2_in = $urandom; imm_in = $urandom;
      v1_in  = ($urandom_range(0, 2) != 0); v2_in = ($urandom_range(0, 2) != 0);
      t1_in  = 6'($urandom_range(0, 7)); t2_in = 6'($urandom_range(0, 7));
      rd_in  = 6'($urandom_range(0, 63)); rdv_in = 1'($urandom_range(0, 1));
      f3_in  = 3'($urandom_range(0, 7)); ls_in = 1'($urandom_range(0, 1));
      cdb_bus.valid = 1'($urandom_range(0, 1));
      cdb_bus.tag   = 6'($urandom_range(0, 7));
      cdb_bus.data  = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/agu_issue_queue_param.md
# agu_issue_queue_param

Parametrised, age-ordered reservation queue for the address generation unit. It holds dispatched load/store micro-ops and captures missing operands from the common data bus (CDB). It selects the oldest ready entry, computes its effective address (op1 + imm) and hands it to the load/store execution unit. It sits between dispatch and the LSU, and replaces the fixed 4-entry, strictly ready-gated AGU queue with configurable depth/width, load-early readiness and dispatch-time CDB bypass.

## Interface
Parameters:
- DEPTH, 4, number of entries; ≥2.
- XLEN, 32, operand/address/immediate width.
- TAG_W, 6, ROB/rename tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- queue_en  in  1  dispatch strobe; accepted only when queue_full=0.
- queue_op1_data_in, queue_op2_data_in  in  XLEN  base register / store data.
- queue_op1_tag_in, queue_op2_tag_in  in  TAG_W  producer tags.
- queue_op1_data_valid_in, queue_op2_data_valid_in  in  1  operand already valid.
- queue_rd_tag_in  in  TAG_W  destination tag.
- queue_rd_tag_valid_in  in  1  destination valid.
- queue_funct3_in  in  3  access size/sign.
- queue_agu_ls_in  in  1  0=load, 1=store.
- queue_agu_imm_in  in  XLEN  sign-extended offset.
- queue_full  out  1  count==DEPTH.
- queue_count  out  $clog2(DEPTH+1)  occupied entries.
- cdb  cdb_if  —  tag, valid, data broadcast.
- ex_done  in  1  LSU accepts the presented entry this cycle.
- issue_valid  out  1  presented entry is ready.
- ex_address  out  XLEN  op1 + imm.
- ex_data  out  XLEN  op2 data.
- queue_rd_tag_out  out  TAG_W; queue_rd_tag_valid_out  out  1; queue_funct3_out  out  3; queue_agu_ls_out  out  1.

## Operation
- Entries are age-ordered: slot 0 is the oldest. A new entry is written at slot queue_count.
- Removal collapses the queue: slots above the issued slot shift down one in the same edge. A same-cycle dispatch lands at count-1.
- CDB capture: each valid entry with opN_valid=0, cdb.valid=1 and cdb.tag==opN_tag latches cdb.data and sets opN_valid. Capture also applies to entries shifting that cycle.
- Dispatch bypass: if an incoming operand is not valid and its tag matches an active CDB broadcast in the same cycle, it is written as valid with cdb.data.
- Ready: a load needs op1_valid. A store needs op1_valid and op2_valid.
- Selection: the lowest-index ready entry, subject to the Configuration rule. issue_valid=1 if one exists.
- Outputs are muxed from the selected slot. All data outputs are driven to 0 when issue_valid=0.
- ex_address = (op1 + imm) mod 2^XLEN. Carry is discarded.
- Issue handshake: the entry is removed at the edge where issue_valid && ex_done. ex_done while issue_valid=0 is ignored.
- queue_count update: count + (dispatch accepted) − (issue accepted).
- queue_en while full is dropped, with no state change. There is no same-cycle full bypass: when full, a simultaneous issue does not admit a dispatch.

## Timing
- Reset (rst=1 at an edge) clears all valid bits and queue_count. Next cycle: queue_full=0, issue_valid=0, queue_count=0, all data outputs 0.
- Reset mid-operation discards all entries. A concurrent dispatch or issue is ignored.
- Dispatch → earliest issue_valid: 1 cycle. This holds also when operands are captured via the dispatch bypass.
- CDB capture at edge N → issue_valid for that entry from cycle N+1.
- issue_valid and the output fields are combinational from registered state, with no CDB→output path in the same cycle.
- queue_full and queue_count are registered-state derived; they update one cycle after the dispatch/issue edge.

## Configuration
- Macro: AGU_STORE_ORDER_EN.
- Defined: an entry is eligible only if no older entry is a store that has not issued. A store is additionally eligible only if it is the oldest valid entry. Stores therefore issue in order, and loads never bypass older stores.
- Undefined: pure oldest-ready selection. Loads and stores may issue in any order once ready.

## Test plan
- Reset, then dispatch 4 loads (DEPTH=4) with valid op1=0x1000+i, imm=4 → queue_full=1 after the 4th. Holding ex_done=1 issues ex_address 0x1004, 0x1005, 0x1006, 0x1007 on consecutive cycles. queue_count ends at 0.
- Load A with op1 tag 5 pending, then load B ready → B issues first. CDB tag 5 data 0x200 → A issues with ex_address 0x200+imm one cycle later.
- Dispatch a store with op2 tag 9 while the CDB broadcasts tag 9 data 0xDEAD in the same cycle → issue_valid next cycle, ex_data=0xDEAD.
- Full queue plus a simultaneous queue_en and issue → dispatch dropped, queue_count 3, queue_full deasserts next cycle.
- Older store (op2 pending) then ready load → with AGU_STORE_ORDER_EN, issue_valid=0 until the store is ready. Without the macro, the load issues immediately.
- op1=0xFFFFFFF0, imm=0x20 → ex_address=0x00000010. rst asserted with 3 entries → next cycle queue_count=0, issue_valid=0.
